// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Purpose:
//    Owns the single-port framebuffer RAM behind the VGA pixel pipeline and
//    shares it between three users, in strict priority order:
//       1. display scanout reads (hard real time, phase-0 slots only),
//       2. the built-in clear-screen sequencer,
//       3. the drawing-engine writer (req/ack handshake).
//    Every cycle is one RAM slot. The RAM interface is fully registered.
//
// Ports:
//    board_clock   system clock, all logic on the rising edge
//    reset         synchronous, active-high reset
//    disp_active   visible-area flag from the VGA timing generator
//    disp_addr     scanout read address, sampled on phase-0 cycles
//    pix_phase     slot phase, toggles every cycle after reset
//    disp_data     scanout pixel, held between reads
//    disp_valid    one-cycle pulse qualifying disp_data (3 cycles after slot)
//    wr_req        writer request, held with stable addr/data until wr_ack
//    wr_addr       writer address
//    wr_data       writer data
//    wr_ack        one-cycle pulse, the write is on the RAM port this cycle
//    clr_start     pulse that starts a clear (ignored while clearing)
//    clr_color     fill value, latched when clr_start is accepted
//    clr_busy      high while a clear is in progress
//    mem_addr      registered RAM address
//    mem_wdata     registered RAM write data
//    mem_we        registered RAM write enable
//    mem_rdata     RAM read data, one cycle after the address
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
   parameter int ADDR_W   = 17,
   parameter int DATA_W   = 8,
   parameter int FB_DEPTH = 76800
) (
   input  logic              board_clock,
   input  logic              reset,
   input  logic              disp_active,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              pix_phase,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_color,
   output logic              clr_busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SLOT_NONE  = 2'd0,
      SLOT_DISP  = 2'd1,
      SLOT_CLEAR = 2'd2,
      SLOT_WRITE = 2'd3
   } slot_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

   state_t            state;
   slot_t             slot;
   logic [ADDR_W-1:0] clr_cnt;
   logic [DATA_W-1:0] clr_color_q;
   logic              rd_issued;
   logic              rd_pending;

   // Decide who owns the RAM port for the slot registered at the end of
   // this cycle. Display only gets phase-0 cycles so the odd cycles are
   // always available to the clear sequencer or the writer, even in active
   // video. The writer is refused while its previous ack is still on the
   // wire so a writer that has not yet dropped wr_req cannot be written
   // twice, and a clr_start arriving in the same idle cycle takes
   // precedence over it.
   always_comb begin
      slot = SLOT_NONE;
      if (!pix_phase && disp_active) begin
         slot = SLOT_DISP;
      end else if (state == CLEAR) begin
         slot = SLOT_CLEAR;
      end else if (wr_req && !wr_ack && !clr_start) begin
         slot = SLOT_WRITE;
      end
   end

   // Main arbiter state machine. All RAM-side signals and the handshake
   // outputs are registered here, so the chosen slot appears on the RAM
   // port one cycle after the decision. mem_addr and mem_wdata simply hold
   // when nobody uses the slot. clr_busy is raised together with the move
   // into CLEAR and is only dropped one idle cycle after leaving CLEAR,
   // which makes it fall the cycle after the final clear write is on the
   // RAM port. The clear counter wraps back to zero on the last address
   // so it never holds a value outside the framebuffer.
   always_ff @(posedge board_clock) begin
      if (reset) begin
         state       <= IDLE;
         pix_phase   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_we      <= 1'b0;
         wr_ack      <= 1'b0;
         rd_issued   <= 1'b0;
         clr_busy    <= 1'b0;
         clr_cnt     <= '0;
         clr_color_q <= '0;
      end else begin
         pix_phase <= ~pix_phase;
         mem_we    <= 1'b0;
         wr_ack    <= 1'b0;
         rd_issued <= 1'b0;

         case (slot)
            SLOT_DISP: begin
               mem_addr  <= disp_addr;
               rd_issued <= 1'b1;
            end
            SLOT_CLEAR: begin
               mem_addr  <= clr_cnt;
               mem_wdata <= clr_color_q;
               mem_we    <= 1'b1;
            end
            SLOT_WRITE: begin
               mem_addr  <= wr_addr;
               mem_wdata <= wr_data;
               mem_we    <= 1'b1;
               wr_ack    <= 1'b1;
            end
            default: begin
            end
         endcase

         case (state)
            IDLE: begin
               if (clr_start) begin
                  state       <= CLEAR;
                  clr_color_q <= clr_color;
                  clr_cnt     <= '0;
                  clr_busy    <= 1'b1;
               end else begin
                  clr_busy <= 1'b0;
               end
            end
            CLEAR: begin
               if (slot == SLOT_CLEAR) begin
                  if (clr_cnt == LAST_ADDR) begin
                     state   <= IDLE;
                     clr_cnt <= '0;
                  end else begin
                     clr_cnt <= clr_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Scanout return path. rd_issued marks the cycle the read address is on
   // the RAM port, rd_pending the cycle the RAM returns the pixel, which is
   // then captured so disp_data/disp_valid land exactly three cycles after
   // the display slot. disp_data holds between reads.
   always_ff @(posedge board_clock) begin
      if (reset) begin
         rd_pending <= 1'b0;
         disp_valid <= 1'b0;
         disp_data  <= '0;
      end else begin
         rd_pending <= rd_issued;
         disp_valid <= rd_pending;
         if (rd_pending) begin
            disp_data <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_arbiter
//
// Purpose:
//    Self-checking bench for vga_fb_arbiter with a small framebuffer
//    (FB_DEPTH=16) and a behavioural synchronous RAM. A vector table drives
//    writer writes followed by scanout reads; hand-written sequences cover
//    active-video writes, write bursts, clears, contention and resets.
// ---------------------------------------------------------------------------
module tb_vga_fb_arbiter;

   localparam int ADDR_W   = 17;
   localparam int DATA_W   = 8;
   localparam int FB_DEPTH = 16;

   logic              board_clock;
   logic              reset;
   logic              disp_active;
   logic [ADDR_W-1:0] disp_addr;
   logic              pix_phase;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              clr_start;
   logic [DATA_W-1:0] clr_color;
   logic              clr_busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   logic [DATA_W-1:0] ram [0:(2**ADDR_W)-1];

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [ADDR_W-1:0] wa;
      logic [DATA_W-1:0] wd;
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] exp_data;
   } vec_t;

   vec_t vecs [6];

   vga_fb_arbiter #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .FB_DEPTH (FB_DEPTH)
   ) dut (
      .board_clock (board_clock),
      .reset       (reset),
      .disp_active (disp_active),
      .disp_addr   (disp_addr),
      .pix_phase   (pix_phase),
      .disp_data   (disp_data),
      .disp_valid  (disp_valid),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_ack      (wr_ack),
      .clr_start   (clr_start),
      .clr_color   (clr_color),
      .clr_busy    (clr_busy),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_rdata   (mem_rdata)
   );

   // 100 MHz board clock.
   initial board_clock = 1'b0;
   always #5 board_clock = ~board_clock;

   // Behavioural single-port synchronous RAM, read-before-write.
   always_ff @(posedge board_clock) begin
      if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr];
   end

   // Hard stop in case a sequence gets stuck somewhere unexpected.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge board_clock);
      #1;
   endtask

   task automatic apply_stimulus(input logic a, input logic s, input logic w);
      disp_active = a;
      clr_start   = s;
      wr_req      = w;
   endtask

   task automatic check_reset_state(input string tag);
      check_output({tag, "_mem_we"},     mem_we,     0);
      check_output({tag, "_mem_addr"},   mem_addr,   0);
      check_output({tag, "_mem_wdata"},  mem_wdata,  0);
      check_output({tag, "_wr_ack"},     wr_ack,     0);
      check_output({tag, "_disp_valid"}, disp_valid, 0);
      check_output({tag, "_disp_data"},  disp_data,  0);
      check_output({tag, "_clr_busy"},   clr_busy,   0);
      check_output({tag, "_pix_phase"},  pix_phase,  0);
   endtask

   // Present one write and wait for its ack; lat is the cycle count from
   // presenting the request to seeing wr_ack.
   task automatic writer_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input string name, output int lat);
      lat     = -1;
      wr_addr = a;
      wr_data = d;
      wr_req  = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (wr_ack) begin
            lat = i;
            check_output({name, "_we"},    mem_we,    1);
            check_output({name, "_addr"},  mem_addr,  a);
            check_output({name, "_wdata"}, mem_wdata, d);
            wr_req = 1'b0;
            break;
         end
      end
      if (lat < 0) begin
         check_output({name, "_ack_timeout"}, 0, 1);
         wr_req = 1'b0;
      end
   endtask

   // One scanout read on a phase-0 cycle, checking the fixed 3-cycle latency.
   task automatic display_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp_d,
                               input string name);
      if (pix_phase) tick();
      disp_active = 1'b1;
      disp_addr   = a;
      tick();
      disp_active = 1'b0;
      check_output({name, "_t1_addr"},  mem_addr,   a);
      check_output({name, "_t1_we"},    mem_we,     0);
      check_output({name, "_t1_valid"}, disp_valid, 0);
      tick();
      check_output({name, "_t2_valid"}, disp_valid, 0);
      tick();
      check_output({name, "_t3_valid"}, disp_valid, 1);
      check_output({name, "_t3_data"},  disp_data,  exp_d);
      tick();
      check_output({name, "_t4_valid"}, disp_valid, 0);
   endtask

   // Run a full clear. Loop index i counts cycles after the first busy
   // cycle. With contend set, a writer request is raised together with
   // clr_start and a second clr_start is pulsed mid-clear.
   task automatic run_clear(input logic [DATA_W-1:0] color, input logic active,
                            input logic contend, input string tag);
      int n_we, first, last, fall, ack_cyc;
      logic [ADDR_W-1:0] exp_a;
      n_we = 0; first = -1; last = -1; fall = -1; ack_cyc = -1; exp_a = '0;
      disp_addr = 17'd5;
      clr_color = color;
      if (contend) begin
         wr_addr = 17'd300;
         wr_data = 8'h66;
      end
      apply_stimulus(active, 1'b1, contend);
      tick();
      clr_start = 1'b0;
      clr_color = 8'h00;
      check_output({tag, "_busy_rise"}, clr_busy, 1);
      check_output({tag, "_no_ack_at_start"}, wr_ack, 0);
      for (int i = 1; i <= 80; i++) begin
         tick();
         clr_start = 1'b0;
         if (mem_we && !wr_ack) begin
            check_output({tag, "_addr"},  mem_addr,  exp_a);
            check_output({tag, "_wdata"}, mem_wdata, color);
            if (active) check_output({tag, "_phase1_slot"}, pix_phase, 0);
            exp_a = exp_a + 1'b1;
            n_we++;
            if (first < 0) first = i;
            last = i;
         end
         if (wr_ack && ack_cyc < 0) begin
            ack_cyc = i;
            check_output({tag, "_ack_while_busy"}, clr_busy, 0);
            wr_req = 1'b0;
         end
         if (fall < 0 && !clr_busy) fall = i;
         if (contend && i == 6) clr_start = 1'b1;
      end
      disp_active = 1'b0;
      check_output({tag, "_write_count"}, n_we, FB_DEPTH);
      if (active) check_output({tag, "_span"}, last - first, 2 * FB_DEPTH - 2);
      else begin
         check_output({tag, "_first"}, first, 1);
         check_output({tag, "_span"}, last - first, FB_DEPTH - 1);
      end
      check_output({tag, "_busy_fall"}, fall, last + 1);
      check_output({tag, "_ram0"},  ram[0],  color);
      check_output({tag, "_ram15"}, ram[15], color);
      if (contend) begin
         check_output({tag, "_ack_cycle"}, ack_cyc, fall);
         check_output({tag, "_ram300"}, ram[300], 8'h66);
      end
      for (int i = 0; i < 4; i++) tick();
   endtask

   initial begin
      int lat;
      int acks;
      int writes;
      int k;
      int ack_cyc [4];
      int found;

      vecs[0] = '{wa: 17'd100,     wd: 8'h3C, ra: 17'd100,     exp_data: 8'h3C};
      vecs[1] = '{wa: 17'd200,     wd: 8'h5A, ra: 17'd200,     exp_data: 8'h5A};
      vecs[2] = '{wa: 17'd100,     wd: 8'hC3, ra: 17'd100,     exp_data: 8'hC3};
      vecs[3] = '{wa: 17'h1FFFF,   wd: 8'hFF, ra: 17'h1FFFF,   exp_data: 8'hFF};
      vecs[4] = '{wa: 17'd0,       wd: 8'h01, ra: 17'd200,     exp_data: 8'h5A};
      vecs[5] = '{wa: 17'd5,       wd: 8'hA5, ra: 17'd5,       exp_data: 8'hA5};

      reset     = 1'b1;
      disp_addr = '0;
      wr_addr   = '0;
      wr_data   = '0;
      clr_color = '0;
      apply_stimulus(1'b0, 1'b0, 1'b0);
      tick();
      tick();
      check_reset_state("por");
      reset = 1'b0;
      tick();
      check_output("phase_toggle_after_reset", pix_phase, 1);
      tick();
      check_output("phase_toggle_again", pix_phase, 0);

      $display("[TB] vector table: writer write then scanout read");
      for (int v = 0; v < 6; v++) begin
         writer_write(vecs[v].wa, vecs[v].wd, $sformatf("vec%0d_wr", v), lat);
         check_output($sformatf("vec%0d_ack_latency", v), lat, 1);
         tick();
         check_output($sformatf("vec%0d_single_ack", v), wr_ack, 0);
         display_read(vecs[v].ra, vecs[v].exp_data, $sformatf("vec%0d_rd", v));
      end

      $display("[TB] writer during active video");
      for (int p = 0; p < 2; p++) begin
         disp_addr   = 17'd5;
         disp_active = 1'b1;
         tick();
         if (pix_phase != p[0]) tick();
         writer_write(17'd100, 8'h3C, $sformatf("active_p%0d", p), lat);
         check_output($sformatf("active_p%0d_lat", p), lat, (p == 0) ? 2 : 1);
         check_output($sformatf("active_p%0d_not_disp_slot", p), pix_phase, 0);
         writes = 0;
         for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_we) writes++;
         end
         check_output($sformatf("active_p%0d_no_dup", p), writes, 0);
         disp_active = 1'b0;
         for (int i = 0; i < 4; i++) tick();
      end
      check_output("active_ram100", ram[100], 8'h3C);

      $display("[TB] writer burst in blanking");
      acks = 0; writes = 0; k = 0;
      wr_addr = 17'd0; wr_data = 8'h10; wr_req = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (mem_we) writes++;
         if (wr_ack && k < 4) begin
            check_output($sformatf("burst%0d_addr", k), mem_addr, k);
            check_output($sformatf("burst%0d_data", k), mem_wdata, 8'h10 + k);
            ack_cyc[k] = i;
            acks++;
            k++;
            if (k < 4) begin
               wr_addr = ADDR_W'(k);
               wr_data = 8'h10 + DATA_W'(k);
            end else begin
               wr_req = 1'b0;
            end
         end
      end
      wr_req = 1'b0;
      check_output("burst_acks", acks, 4);
      check_output("burst_writes", writes, 4);
      if (acks == 4) begin
         check_output("burst_first_ack", ack_cyc[0], 1);
         for (int j = 1; j < 4; j++)
            check_output($sformatf("burst_gap%0d", j), ack_cyc[j] - ack_cyc[j-1], 2);
      end
      for (int j = 0; j < 4; j++)
         check_output($sformatf("burst_ram%0d", j), ram[j], 8'h10 + j);

      $display("[TB] clear sequences");
      run_clear(8'h07, 1'b0, 1'b0, "clr_blank");
      run_clear(8'h2B, 1'b1, 1'b0, "clr_active");
      run_clear(8'h44, 1'b0, 1'b1, "clr_contend");

      $display("[TB] reset during clear");
      clr_color = 8'h99;
      apply_stimulus(1'b0, 1'b1, 1'b0);
      tick();
      clr_start = 1'b0;
      found = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (mem_we && mem_addr == 17'd4) begin
            found = 1;
            break;
         end
      end
      check_output("rst_clr_reached_cnt5", found, 1);
      reset = 1'b1;
      tick();
      check_reset_state("rst_clr_c1");
      tick();
      check_reset_state("rst_clr_c2");
      reset = 1'b0;
      writes = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (mem_we) writes++;
         if (i == 0) check_output("rst_clr_phase_after", pix_phase, 1);
      end
      check_output("rst_clr_no_more_writes", writes, 0);
      check_output("rst_clr_busy_low", clr_busy, 0);
      check_output("rst_clr_ram5_untouched", ram[5], 8'h44);

      $display("[TB] reset during writer handshake");
      wr_addr = 17'd7; wr_data = 8'h77; wr_req = 1'b1;
      tick();
      check_output("rst_hs_first_ack", wr_ack, 1);
      reset = 1'b1;
      tick();
      check_output("rst_hs_ack_dropped", wr_ack, 0);
      reset = 1'b0;
      tick();
      check_output("rst_hs_served_ack", wr_ack, 1);
      check_output("rst_hs_served_addr", mem_addr, 17'd7);
      wr_req = 1'b0;
      tick();
      check_output("rst_hs_ram7", ram[7], 8'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Owns the single-port framebuffer RAM behind the VGA pixel pipeline.
- Shares that RAM between three users:
  - display scanout reads, which have hard real-time priority;
  - a drawing-engine writer using a req/ack handshake;
  - a built-in clear-screen sequencer.
- Sits between the VGA timing generator (which supplies disp_active) and the framebuffer RAM.

Parameters:
- ADDR_W, 17, framebuffer address width.
- DATA_W, 8, pixel width.
- FB_DEPTH, 76800, number of pixels cleared by the clear sequencer (320x240).

Ports:
- board_clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- disp_active  in  1  high during the visible area, from VGA timing.
- disp_addr  in  ADDR_W  scanout read address; sampled on phase-0 cycles.
- pix_phase  out  1  slot phase. Display logic presents disp_addr while pix_phase=0.
- disp_data  out  DATA_W  scanout pixel.
- disp_valid  out  1  one-cycle pulse qualifying disp_data.
- wr_req  in  1  writer request; held with stable wr_addr/wr_data until wr_ack.
- wr_addr  in  ADDR_W  writer address.
- wr_data  in  DATA_W  writer data.
- wr_ack  out  1  one-cycle pulse; the write is being issued this cycle.
- clr_start  in  1  pulse to begin clearing the framebuffer.
- clr_color  in  DATA_W  fill value, latched on an accepted clr_start.
- clr_busy  out  1  high while a clear is in progress.
- mem_addr  out  ADDR_W  RAM address, registered.
- mem_wdata  out  DATA_W  RAM write data, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_rdata  in  DATA_W  RAM read data; synchronous RAM with 1-cycle read latency.

Behaviour:
- Reset: all outputs 0, pix_phase 0, state IDLE, clear counter 0. Reset mid-clear aborts the clear. Reset mid-handshake drops the pending grant; the writer keeps wr_req high and is served after reset.
- pix_phase toggles every cycle after reset.
- Slot decision, once per cycle t, in strict priority order:
  1. Display: pix_phase=0 and disp_active=1. Registers mem_addr=disp_addr, mem_we=0.
  2. Clear: state CLEAR. Registers mem_addr=clr_cnt, mem_wdata=clr_color latched, mem_we=1.
  3. Writer: wr_req=1, state IDLE and wr_ack=0 in cycle t. Registers wr_addr/wr_data with mem_we=1, and wr_ack=1 at t+1.
  4. None: mem_we=0; mem_addr holds its value.
- The "wr_ack=0 in cycle t" condition forbids back-to-back writer grants. This prevents a double write while the writer is still reacting to an ack. Maximum writer rate is 1 per 2 cycles.
- Display latency:
  - slot at cycle t; mem_addr visible at t+1; mem_rdata valid at t+2;
  - disp_data registered with disp_valid=1 at t+3, fixed;
  - disp_valid=0 on all other cycles; disp_data holds its last value.
- disp_active=1 on a phase-1 cycle does not create a display slot; that slot is free for clear or writer.
- State machine:
  - IDLE -> CLEAR on clr_start=1: latch clr_color, set clr_cnt=0, clr_busy=1 from the next cycle.
  - In CLEAR, clr_cnt increments after each clear slot.
  - After the slot issuing address FB_DEPTH-1, go to IDLE. clr_busy falls the cycle after the final mem_we.
  - clr_start while CLEAR is ignored.
  - wr_req is never acked during CLEAR.
  - clr_start and wr_req in the same IDLE cycle: clear wins, no ack.
- clr_cnt is ADDR_W bits and never exceeds FB_DEPTH-1.

Test Plan:
- Reset during a clear: reset high for 2 cycles at clr_cnt=5 -> next cycle all outputs 0, clr_busy 0, pix_phase 0; no further mem_we until a new request.
- Display read: RAM model holds addr 5 = 0xA5; disp_active=1, disp_addr=5 on a pix_phase=0 cycle t -> mem_addr=5 with mem_we=0 at t+1; disp_valid=1 and disp_data=0xA5 at exactly t+3.
- Writer during active video: disp_active=1, wr_req with addr 100, data 0x3C -> wr_ack within 3 cycles, never aligned with a display slot. mem_we=1, mem_addr=100, mem_wdata=0x3C occur in the same cycle as wr_ack; exactly one write.
- Writer burst in blanking: disp_active=0, 4 queued writes to addrs 0..3 with data 0x10..0x13 -> acks every 2nd cycle, 4 acks total, RAM contents match, no duplicate writes.
- Clear: FB_DEPTH=16, clr_color=0x07, disp_active=0 -> mem_we on 16 consecutive cycles covering addrs 0..15, clr_busy falls 1 cycle after the last write. With disp_active=1 -> writes only on phase-1 slots, 32 cycles total.
- Contention: clr_start and wr_req in the same cycle -> clear runs to completion and wr_ack is held off until clr_busy=0. A second clr_start mid-clear has no effect: still 16 writes.
